// File: rtl/can_crc_engine.sv
// can_crc_engine: parallel CRC-15/17/21 generator and receive CRC checker for
// the CAN / CAN FD receive path. Sits between the bit destuffer and the
// frame-level error logic.
// Optional feature: define CAN_CRC_ERR_CNT_EN to add the saturating
// crc_err_cnt output (mismatch counter, cleared only by rst_n).
module can_crc_engine #(
    parameter logic [14:0] CRC15_POLY     = 15'h4599,
    parameter logic [16:0] CRC17_POLY     = 17'h1685B,
    parameter logic [20:0] CRC21_POLY     = 21'h102899,
    parameter logic [16:0] CRC17_INIT_ISO = 17'h10000,
    parameter logic [20:0] CRC21_INIT_ISO = 21'h100000
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        init,
    input  logic        fd_iso,
    input  logic        fd_frame,
    input  logic        dlc_gt16,
    input  logic        bit_valid,
    input  logic        data,
    input  logic        stuff_bit,
    input  logic        fixed_stuff,
    input  logic        crc_field_start,
    output logic [14:0] crc_15,
    output logic [16:0] crc_17,
    output logic [20:0] crc_21,
    output logic [4:0]  crc_len,
`ifdef CAN_CRC_ERR_CNT_EN
    output logic [7:0]  crc_err_cnt,
`endif
    output logic        busy,
    output logic        crc_done,
    output logic        crc_ok,
    output logic        crc_err
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        CALC  = 2'd1,
        RXCRC = 2'd2,
        DONE  = 2'd3
    } state_t;

    state_t      state_q, state_d;
    logic [14:0] crc15_q, crc15_d;
    logic [16:0] crc17_q, crc17_d;
    logic [20:0] crc21_q, crc21_d;
    logic [20:0] rx_q, rx_d;
    logic [4:0]  cnt_q, cnt_d;
    logic [4:0]  len_q, len_d;
    logic        fd_q, fd_d;
    logic        done_q, done_d;
    logic        ok_q, ok_d;
    logic        err_q, err_d;

    logic [14:0] crc15_step;
    logic [16:0] crc17_step;
    logic [20:0] crc21_step;
    logic        rx_match;
    logic        rx_drop;
    logic        cmp_fire;

    // One-bit LFSR step of each CRC for the current input bit.
    always_comb begin
        crc15_step = {crc15_q[13:0], 1'b0} ^ ((data ^ crc15_q[14]) ? CRC15_POLY : 15'd0);
        crc17_step = {crc17_q[15:0], 1'b0} ^ ((data ^ crc17_q[16]) ? CRC17_POLY : 17'd0);
        crc21_step = {crc21_q[19:0], 1'b0} ^ ((data ^ crc21_q[20]) ? CRC21_POLY : 21'd0);
    end

    // Compare the received field against the frozen CRC of the selected length.
    always_comb begin
        rx_match = 1'b0;
        case (len_q)
            5'd15:   rx_match = (rx_q[14:0] == crc15_q);
            5'd17:   rx_match = (rx_q[16:0] == crc17_q);
            5'd21:   rx_match = (rx_q == crc21_q);
            default: rx_match = 1'b0;
        endcase
    end

    // FD fields carry fixed stuff bits, classic fields carry dynamic ones;
    // the comparison fires one cycle after the last field bit was captured.
    assign rx_drop  = fd_q ? fixed_stuff : stuff_bit;
    assign cmp_fire = (state_q == RXCRC) && (cnt_q == len_q) && !init;

    // Next-state logic: init first, then per-state bit handling.
    always_comb begin
        state_d = state_q;
        crc15_d = crc15_q;
        crc17_d = crc17_q;
        crc21_d = crc21_q;
        rx_d    = rx_q;
        cnt_d   = cnt_q;
        len_d   = len_q;
        fd_d    = fd_q;
        done_d  = 1'b0;
        ok_d    = ok_q;
        err_d   = err_q;

        if (init) begin
            state_d = CALC;
            crc15_d = 15'd0;
            crc17_d = fd_iso ? CRC17_INIT_ISO : 17'd0;
            crc21_d = fd_iso ? CRC21_INIT_ISO : 21'd0;
            rx_d    = 21'd0;
            cnt_d   = 5'd0;
            len_d   = 5'd0;
            ok_d    = 1'b0;
            err_d   = 1'b0;
        end else begin
            case (state_q)
                CALC: begin
                    if (bit_valid) begin
                        if (crc_field_start) begin
                            // First CRC-field bit: pick the CRC, freeze LFSRs.
                            if (!fd_frame) begin
                                len_d = 5'd15;
                            end else if (!dlc_gt16) begin
                                len_d = 5'd17;
                            end else begin
                                len_d = 5'd21;
                            end
                            fd_d    = fd_frame;
                            rx_d    = {20'd0, data};
                            cnt_d   = 5'd1;
                            state_d = RXCRC;
                        end else begin
                            // CRC-15 excludes dynamic stuff bits; FD CRCs include them.
                            if (!stuff_bit) begin
                                crc15_d = crc15_step;
                            end
                            crc17_d = crc17_step;
                            crc21_d = crc21_step;
                        end
                    end
                end
                RXCRC: begin
                    if (cmp_fire) begin
                        done_d  = 1'b1;
                        ok_d    = rx_match;
                        err_d   = !rx_match;
                        state_d = DONE;
                    end else if (bit_valid && !rx_drop) begin
                        rx_d  = {rx_q[19:0], data};
                        cnt_d = cnt_q + 5'd1;
                    end
                end
                default: begin
                    // IDLE and DONE hold everything until init.
                end
            endcase
        end
    end

    // State and datapath registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            crc15_q <= 15'd0;
            crc17_q <= 17'd0;
            crc21_q <= 21'd0;
            rx_q    <= 21'd0;
            cnt_q   <= 5'd0;
            len_q   <= 5'd0;
            fd_q    <= 1'b0;
            done_q  <= 1'b0;
            ok_q    <= 1'b0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            crc15_q <= crc15_d;
            crc17_q <= crc17_d;
            crc21_q <= crc21_d;
            rx_q    <= rx_d;
            cnt_q   <= cnt_d;
            len_q   <= len_d;
            fd_q    <= fd_d;
            done_q  <= done_d;
            ok_q    <= ok_d;
            err_q   <= err_d;
        end
    end

`ifdef CAN_CRC_ERR_CNT_EN
    logic [7:0] err_cnt_q;

    // Saturating count of mismatching comparisons; survives init.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            err_cnt_q <= 8'd0;
        end else if (cmp_fire && !rx_match && (err_cnt_q != 8'hFF)) begin
            err_cnt_q <= err_cnt_q + 8'd1;
        end
    end

    assign crc_err_cnt = err_cnt_q;
`endif

    assign crc_15   = crc15_q;
    assign crc_17   = crc17_q;
    assign crc_21   = crc21_q;
    assign crc_len  = len_q;
    assign busy     = (state_q == CALC) || (state_q == RXCRC);
    assign crc_done = done_q;
    assign crc_ok   = ok_q;
    assign crc_err  = err_q;

endmodule
